seq_cla_adder_ctrl: RTL and testbench
=====================================

// Module: seq_cla_adder_ctrl
//
// PURPOSE
//   Sequencer that adds two WIDTH-bit operands by iterating one 4-bit
//   propagate/generate + carry-lookahead slice over WIDTH/4 clock cycles.
//   The carry is registered between slices. Sits between a requester
//   (start/done handshake) and the shared 4-bit PG/CLA datapath, so that
//   wide adds reuse one small lookahead slice.
//
// PARAMETERS
//   WIDTH   16   operand/sum width; must be a multiple of 4 (>= 4)
//   NSLICE  WIDTH/4   derived (localparam); number of RUN cycles
//
// PORTS
//   clk     in   1      single clock; all state updates on posedge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  operand A; latched when start is accepted
//   b       in   WIDTH  operand B; latched when start is accepted
//   cin     in   1      carry-in; latched when start is accepted
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse: sum/cout valid
//   sum     out  WIDTH  result; holds its value until the next accepted start
//   cout    out  1      carry-out of bit WIDTH-1
//   ovf     out  1      signed overflow (only with OVF_DETECT_EN)
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge, in any state including mid-RUN):
//     state=IDLE; busy=0; done=0; sum=0; cout=0; ovf=0; slice idx=0;
//     carry reg=0; latched operands=0.
//   - FSM states and transitions:
//     IDLE --start--> RUN
//     RUN  --idx==NSLICE-1--> DONE
//     DONE --start--> RUN
//     DONE --!start--> IDLE
//   - Accepting start: at the accepting edge, latch a, b, cin;
//     set idx=0, carry=cin, busy=1.
//   - RUN, slice idx i (bits 4i+3..4i) each cycle:
//     - p=a_l^b_l; g=a_l&b_l.
//     - c1=g0|p0c0; c2=g1|p1g0|p1p0c0; c3 and c4 by the same expansion.
//     - sum[4i+3:4i] <= p ^ {c3,c2,c1,c0}.
//     - carry <= c4; idx <= i+1.
//   - Last slice (i=NSLICE-1): cout <= c4; busy <= 0; done <= 1;
//     state <= DONE.
//   - Latency: start accepted at edge E0; done=1 during the cycle after
//     edge E(NSLICE). For WIDTH=16, done is seen 4 cycles after the
//     accepting edge.
//   - done stays high exactly 1 cycle. A start in that same DONE cycle
//     is accepted: back-to-back operation with no bubble, and done
//     drops because busy=1.
//   - start while busy: ignored. Latched operands and sequence are
//     unaffected.
//   - Input changes on a/b/cin while busy: no effect.
//   - sum bits of slices not yet processed keep their previous values.
//     sum is only meaningful once done has pulsed.
//   - Widths: no truncation except the final carry, which goes to cout.
//     sum wraps modulo 2^WIDTH.
//
// CONFIGURATION
//   OVF_DETECT_EN defined:
//     - Port ovf present.
//     - On the last slice, ovf <= c3 ^ c4 (carry into MSB XOR carry out).
//     - ovf is valid with done, reset to 0, and held until the next
//       accepted start, where it clears to 0.
//   OVF_DETECT_EN undefined:
//     - Port ovf absent; no overflow logic is synthesised.
//
// TESTING (WIDTH=16)
//   1. a=0x0005, b=0x0005, cin=0, start 1 cycle
//      -> busy for 4 cycles, then done; sum=0x000A, cout=0.
//   2. a=0xFFFF, b=0x0001, cin=0
//      -> sum=0x0000, cout=1 (carry crosses all 4 slices).
//   3. a=0x00FF, b=0x0000, cin=1
//      -> sum=0x0100, cout=0.
//      Then immediately a=0x1234, b=0x4321 with start held in the DONE
//      cycle -> second done 4 cycles later, sum=0x5555.
//   4. a=0x0F0F, b=0x0101 started; at cycle 2 apply start with
//      a=0xFFFF, b=0xFFFF
//      -> ignored; sum=0x1010, cout=0, exactly one done pulse.
//   5. a=0xFFFF, b=0xFFFF started; rst=1 in cycle 2 of RUN
//      -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE.
//      A new start with 0x0001+0x0001 gives sum=0x0002.
//   6. [OVF_DETECT_EN] 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
//      0xFFFF+0x0001 -> ovf=0, cout=1.
//      0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1.

Source files
------------

// File: rtl/seq_cla_adder_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit PG/carry-lookahead slice is reused over WIDTH/4 cycles.
// Optional signed-overflow output is built only when OVF_DETECT_EN is defined.
module seq_cla_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
`ifdef OVF_DETECT_EN
  logic             ovf_q;
`endif

  logic [IDXW+1:0]  base;
  logic [3:0]       a_sl;
  logic [3:0]       b_sl;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [4:0]       c;
  logic [3:0]       sum_sl_d;
  logic [IDXW-1:0]  idx_d;
  logic             last_slice;
  logic             accept;

  // Bit offset of the active slice within the latched operands.
  assign base = {idx_q, 2'b00};
  assign a_sl = a_q[base +: 4];
  assign b_sl = b_q[base +: 4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pg
      assign p[gi] = a_sl[gi] ^ b_sl[gi];
      assign g[gi] = a_sl[gi] & b_sl[gi];
    end
  endgenerate

  // Fully expanded lookahead: every carry depends only on p, g and the slice carry-in.
  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_sl_d   = p ^ c[3:0];
  assign idx_d      = idx_q + IDXW'(1);
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));
  assign accept     = start && (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            // Unprocessed sum slices keep their old value until overwritten.
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef OVF_DETECT_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_q[base +: 4] <= sum_sl_d;
          carry_q          <= c[4];
          if (last_slice) begin
            idx_q   <= '0;
            cout_q  <= c[4];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef OVF_DETECT_EN
            ovf_q   <= c[3] ^ c[4];
`endif
          end else begin
            idx_q <= idx_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef OVF_DETECT_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_cla_adder_ctrl.sv
// Self-checking bench for seq_cla_adder_ctrl (WIDTH=16): directed cases plus random operands
// compared against plain integer addition.
module tb_seq_cla_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVF_DETECT_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  seq_cla_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef OVF_DETECT_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 17-bit integer sum; overflow from operand/result signs.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a = x; b = y; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_done", done, 1'b0);
  endtask

  // Runs the remaining RUN cycles after acceptance and checks the done cycle.
  // Operands are scrambled meanwhile; inject_k>0 raises start at that busy cycle.
  task automatic finish_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input int inject_k);
    logic [W:0] r;
    r = ref_add(x, y, ci);
    for (int k = 1; k <= 3; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (k == inject_k) begin
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      end
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_early_done"}, done, 1'b0);
    end
    tick();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_sum"}, sum, r[W-1:0]);
    chk({tag, "_cout"}, cout, r[W]);
`ifdef OVF_DETECT_EN
    chk({tag, "_ovf"}, ovf, ref_ovf(x, y, r[W-1:0]));
`endif
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d", tag, x, y, ci, sum, cout);
  endtask

  task automatic single_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci);
    logic [W:0] r;
    r = ref_add(x, y, ci);
    drive_start(x, y, ci);
    finish_op(tag, x, y, ci, 0);
    tick();
    chk({tag, "_pulse_end"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_sum_hold"}, sum, r[W-1:0]);
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic         ci;
    logic [W:0]   r;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
`ifdef OVF_DETECT_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    tick();

    single_op("t1", 16'h0005, 16'h0005, 1'b0);
    single_op("t2", 16'hFFFF, 16'h0001, 1'b0);

    // Back-to-back: start held during the DONE cycle.
    drive_start(16'h00FF, 16'h0000, 1'b1);
    finish_op("t3a", 16'h00FF, 16'h0000, 1'b1, 0);
    drive_start(16'h1234, 16'h4321, 1'b0);
    finish_op("t3b", 16'h1234, 16'h4321, 1'b0, 0);
    tick();
    chk("t3b_pulse_end", done, 1'b0);

    // Start while busy is ignored; exactly one done pulse.
    drive_start(16'h0F0F, 16'h0101, 1'b0);
    finish_op("t4", 16'h0F0F, 16'h0101, 1'b0, 2);
    tick();
    chk("t4_single_pulse", done, 1'b0);
    tick();
    chk("t4_still_idle", done, 1'b0);

    // Reset in the middle of RUN.
    drive_start(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_sum", sum, 16'h0000);
    chk("t5_rst_cout", cout, 1'b0);
    tick();
    chk("t5_idle_done", done, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);
    single_op("t5b", 16'h0001, 16'h0001, 1'b0);

`ifdef OVF_DETECT_EN
    single_op("t6a", 16'h7FFF, 16'h0001, 1'b0);
    single_op("t6b", 16'hFFFF, 16'h0001, 1'b0);
    single_op("t6c", 16'h8000, 16'h8000, 1'b0);
`endif

    // Random operands, randomly chained back-to-back.
    for (int n = 0; n < 40; n++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      r = ref_add(x, y, ci);
      drive_start(x, y, ci);
      finish_op("rnd", x, y, ci, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) begin
        tick();
        chk("rnd_pulse_end", done, 1'b0);
        chk("rnd_sum_hold", sum, r[W-1:0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
